// File: rtl/moore_pkg.sv
// ---------------------------------------------------------------------------
// moore_pkg
// Shared types for the run tracker: the FSM state encoding and the motion
// direction encoding that appears on the tracker's dir output.
// ---------------------------------------------------------------------------
package moore_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_t;

    // 2'b11 is never produced.
    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_FWD  = 2'b01,
        DIR_REV  = 2'b10
    } dir_t;

endpackage

// File: rtl/run_decode.sv
// ---------------------------------------------------------------------------
// run_decode
// Combinational classifier for one sensor sample.
//   ip     : sensor vector, bit N-1 is position 0
//   valid  : exactly one contiguous run of ones, length in [RUN_MIN, RUN_MAX]
//   absent : all-zero vector
//   pos    : position of the run's leftmost one (meaningful when valid)
//   len    : number of ones in ip
// ---------------------------------------------------------------------------
module run_decode #(
    parameter int N       = 6,
    parameter int RUN_MIN = 2,
    parameter int RUN_MAX = 3
) (
    input  logic [N-1:0]           ip,
    output logic                   valid,
    output logic                   absent,
    output logic [$clog2(N)-1:0]   pos,
    output logic [$clog2(N+1)-1:0] len
);

    localparam int POS_W = $clog2(N);
    localparam int WID_W = $clog2(N+1);

    logic [N-1:0]     lsb_s;
    logic [N-1:0]     sum_s;
    logic             contig_s;
    logic [POS_W-1:0] pos_s;
    logic [WID_W-1:0] len_s;

    // Adding the lowest set bit ripples a carry through the lowest run of
    // ones and clears it; any one left behind means a second run exists.
    assign lsb_s    = ip & (~ip + {{(N-1){1'b0}}, 1'b1});
    assign sum_s    = ip + lsb_s;
    assign contig_s = ((sum_s & ip) == {N{1'b0}});

    // Popcount and leftmost-one position; ascending scan so the highest set
    // bit (smallest position) is the last write.
    always_comb begin
        pos_s = {POS_W{1'b0}};
        len_s = {WID_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            len_s = len_s + WID_W'(ip[i]);
            if (ip[i]) begin
                pos_s = POS_W'(N - 1 - i);
            end else begin
                pos_s = pos_s;
            end
        end
    end

    assign absent = (ip == {N{1'b0}});
    assign valid  = contig_s && (len_s >= WID_W'(RUN_MIN)) && (len_s <= WID_W'(RUN_MAX));
    assign pos    = pos_s;
    assign len    = len_s;

endmodule

// File: rtl/moore_run_tracker.sv
// ---------------------------------------------------------------------------
// moore_run_tracker
// Moore FSM that follows a single run of ones moving across an N-bit sensor
// strip. Every output comes straight from a flop.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   en       : sample strobe, ip is only looked at when high
//   clr      : leaves ERROR, zeroes steps and the bad-sample count
//   ip       : sensor vector, bit N-1 is position 0
//   out      : held position of the run's leftmost one
//   width    : held run length
//   dir      : 00 hold, 01 forward, 10 reverse
//   trk, err : state flags for TRACK and ERROR
//   steps    : saturating count of legal position changes
// ---------------------------------------------------------------------------
module moore_run_tracker
    import moore_pkg::*;
#(
    parameter int N         = 6,
    parameter int RUN_MIN   = 2,
    parameter int RUN_MAX   = 3,
    parameter int ERR_LIMIT = 2,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic [N-1:0]           ip,
    output logic [$clog2(N)-1:0]   out,
    output logic [$clog2(N+1)-1:0] width,
    output logic [1:0]             dir,
    output logic                   trk,
    output logic                   err,
    output logic [CNT_W-1:0]       steps
);

    localparam int POS_W = $clog2(N);
    localparam int WID_W = $clog2(N+1);
    localparam int BAD_W = $clog2(ERR_LIMIT + 1);

    state_t           state_q, state_d;
    logic [POS_W-1:0] out_q,   out_d;
    logic [WID_W-1:0] width_q, width_d;
    dir_t             dir_q,   dir_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [BAD_W-1:0] bad_q,   bad_d;
    logic             trk_q,   trk_d;
    logic             err_q,   err_d;

    logic             dec_valid_s;
    logic             dec_absent_s;
    logic [POS_W-1:0] dec_pos_s;
    logic [WID_W-1:0] dec_len_s;

    logic             same_s;
    logic             fwd_s;
    logic             rev_s;
    logic             legal_s;
    logic [BAD_W:0]   bad_inc_s;
    logic             bad_hit_s;

    run_decode #(
        .N       (N),
        .RUN_MIN (RUN_MIN),
        .RUN_MAX (RUN_MAX)
    ) u_decode (
        .ip     (ip),
        .valid  (dec_valid_s),
        .absent (dec_absent_s),
        .pos    (dec_pos_s),
        .len    (dec_len_s)
    );

    // One extra bit so out_q+1 at the last position cannot wrap to 0.
    assign same_s    = (dec_pos_s == out_q);
    assign fwd_s     = ({1'b0, dec_pos_s} == ({1'b0, out_q} + {{POS_W{1'b0}}, 1'b1}));
    assign rev_s     = ({1'b0, out_q} == ({1'b0, dec_pos_s} + {{POS_W{1'b0}}, 1'b1}));
    assign legal_s   = dec_valid_s && (same_s || fwd_s || rev_s);
    assign bad_inc_s = {1'b0, bad_q} + {{BAD_W{1'b0}}, 1'b1};
    assign bad_hit_s = (bad_inc_s >= (BAD_W+1)'(ERR_LIMIT));

    // Next-state, hold-register, counter and flag computation.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        width_d = width_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        bad_d   = bad_q;

        if (clr) begin
            // clr outranks a coincident sample, which is dropped.
            state_d = IDLE;
            steps_d = {CNT_W{1'b0}};
            bad_d   = {BAD_W{1'b0}};
            dir_d   = DIR_HOLD;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (dec_valid_s) begin
                        state_d = TRACK;
                        out_d   = dec_pos_s;
                        width_d = dec_len_s;
                        dir_d   = DIR_HOLD;
                        bad_d   = {BAD_W{1'b0}};
                    end else if (dec_absent_s) begin
                        bad_d   = {BAD_W{1'b0}};
                    end else begin
                        bad_d = bad_inc_s[BAD_W-1:0];
                        if (bad_hit_s) begin
                            state_d = ERROR;
                            dir_d   = DIR_HOLD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                TRACK: begin
                    if (legal_s) begin
                        out_d   = dec_pos_s;
                        width_d = dec_len_s;
                        bad_d   = {BAD_W{1'b0}};
                        if (fwd_s) begin
                            dir_d = DIR_FWD;
                        end else if (rev_s) begin
                            dir_d = DIR_REV;
                        end else begin
                            dir_d = DIR_HOLD;
                        end
                        if (!same_s && (steps_q != {CNT_W{1'b1}})) begin
                            steps_d = steps_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            steps_d = steps_q;
                        end
                    end else if (dec_absent_s) begin
                        state_d = IDLE;
                        dir_d   = DIR_HOLD;
                        bad_d   = {BAD_W{1'b0}};
                    end else begin
                        // Malformed pattern or a jump of more than one position.
                        bad_d = bad_inc_s[BAD_W-1:0];
                        if (bad_hit_s) begin
                            state_d = ERROR;
                            dir_d   = DIR_HOLD;
                        end else begin
                            state_d = TRACK;
                        end
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                    dir_d   = DIR_HOLD;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        trk_d = (state_d == TRACK);
        err_d = (state_d == ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= {POS_W{1'b0}};
            width_q <= {WID_W{1'b0}};
            dir_q   <= DIR_HOLD;
            steps_q <= {CNT_W{1'b0}};
            bad_q   <= {BAD_W{1'b0}};
            trk_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            width_q <= width_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
            bad_q   <= bad_d;
            trk_q   <= trk_d;
            err_q   <= err_d;
        end
    end

    assign out   = out_q;
    assign width = width_q;
    assign dir   = dir_q;
    assign trk   = trk_q;
    assign err   = err_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_moore_run_tracker.sv
// ---------------------------------------------------------------------------
// tb_moore_run_tracker
// Two trackers share one stimulus stream: dut_a with defaults, dut_b with
// ERR_LIMIT=1 and CNT_W=2. Directed tasks check values from the test plan;
// the random task checks both against a behavioural model.
// ---------------------------------------------------------------------------
module tb_moore_run_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] ip  = 6'd0;

    logic [2:0] out_a, width_a, out_b, width_b;
    logic [1:0] dir_a, dir_b;
    logic       trk_a, err_a, trk_b, err_b;
    logic [7:0] steps_a;
    logic [1:0] steps_b;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        int mode;   // 0 idle, 1 track, 2 error
        int out;
        int width;
        int dir;
        int steps;
        int bad;
    } mstate_t;

    mstate_t ma, mb;

    always #5 clk = ~clk;

    moore_run_tracker dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ip(ip),
        .out(out_a), .width(width_a), .dir(dir_a),
        .trk(trk_a), .err(err_a), .steps(steps_a)
    );

    moore_run_tracker #(.ERR_LIMIT(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ip(ip),
        .out(out_b), .width(width_b), .dir(dir_b),
        .trk(trk_b), .err(err_b), .steps(steps_b)
    );

    // Classify a sample: kind 0 absent, 1 valid, 2 bad.
    function automatic void classify(input logic [5:0] v, output int kind, output int p, output int l);
        int first = -1;
        int last  = -1;
        l = 0;
        for (int j = 0; j < 6; j++) begin
            if (v[5-j]) begin
                l++;
                if (first < 0) first = j;
                last = j;
            end
        end
        p = (first < 0) ? 0 : first;
        if (l == 0) kind = 0;
        else if (l >= 2 && l <= 3 && (last - first + 1) == l) kind = 1;
        else kind = 2;
    endfunction

    function automatic mstate_t mstep(input mstate_t m, input bit r, input bit c, input bit e,
                                      input logic [5:0] v, input int lim, input int smax);
        mstate_t n = m;
        int kind, p, l, d;
        classify(v, kind, p, l);
        if (r) begin
            n.mode = 0; n.out = 0; n.width = 0; n.dir = 0; n.steps = 0; n.bad = 0;
        end else if (c) begin
            n.mode = 0; n.steps = 0; n.bad = 0; n.dir = 0;
        end else if (e) begin
            if (m.mode == 0) begin
                if (kind == 1) begin
                    n.mode = 1; n.out = p; n.width = l; n.dir = 0; n.bad = 0;
                end else if (kind == 0) begin
                    n.bad = 0;
                end else begin
                    n.bad = m.bad + 1;
                    if (n.bad >= lim) begin n.mode = 2; n.dir = 0; end
                end
            end else if (m.mode == 1) begin
                d = p - m.out;
                if (kind == 1 && d >= -1 && d <= 1) begin
                    n.dir = (d > 0) ? 1 : (d < 0) ? 2 : 0;
                    if (d != 0 && m.steps < smax) n.steps = m.steps + 1;
                    n.out = p; n.width = l; n.bad = 0;
                end else if (kind == 0) begin
                    n.mode = 0; n.dir = 0; n.bad = 0;
                end else begin
                    n.bad = m.bad + 1;
                    if (n.bad >= lim) begin n.mode = 2; n.dir = 0; end
                end
            end
        end
        return n;
    endfunction

    task automatic apply(input bit r, input bit c, input bit e, input logic [5:0] v);
        rst = r; clr = c; en = e; ip = v;
        @(posedge clk);
        #1;
        ma = mstep(ma, r, c, e, v, 2, 255);
        mb = mstep(mb, r, c, e, v, 1, 3);
        rst = 1'b0; clr = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 1'b1, 6'b111000);
        vectors++; if (out_a !== 3'd0)   begin fails++; $display("FAIL reset.out got %0d want 0", out_a); end
        vectors++; if (width_a !== 3'd0) begin fails++; $display("FAIL reset.width got %0d want 0", width_a); end
        vectors++; if (dir_a !== 2'd0)   begin fails++; $display("FAIL reset.dir got %0d want 0", dir_a); end
        vectors++; if (trk_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL reset.flags got trk=%0d err=%0d want 0 0", trk_a, err_a); end
        vectors++; if (steps_a !== 8'd0) begin fails++; $display("FAIL reset.steps got %0d want 0", steps_a); end
        vectors++; if (trk_b !== 1'b0 || err_b !== 1'b0 || steps_b !== 2'd0) begin fails++; $display("FAIL reset.b got trk=%0d err=%0d steps=%0d want 0 0 0", trk_b, err_b, steps_b); end
    endtask

    task automatic test_track_start();
        apply(1'b0, 1'b0, 1'b1, 6'b111000);
        vectors++; if (out_a !== 3'd0 || width_a !== 3'd3) begin fails++; $display("FAIL start.pos got out=%0d width=%0d want 0 3", out_a, width_a); end
        vectors++; if (trk_a !== 1'b1 || dir_a !== 2'd0) begin fails++; $display("FAIL start.trk got trk=%0d dir=%0d want 1 0", trk_a, dir_a); end
        apply(1'b0, 1'b0, 1'b1, 6'b011100);
        vectors++; if (out_a !== 3'd1 || dir_a !== 2'd1 || steps_a !== 8'd1) begin fails++; $display("FAIL start.step got out=%0d dir=%0d steps=%0d want 1 1 1", out_a, dir_a, steps_a); end
    endtask

    task automatic test_sweep();
        logic [5:0] fwd [5];
        logic [5:0] rev [4];
        fwd = '{6'b110000, 6'b011000, 6'b001100, 6'b000110, 6'b000011};
        rev = '{6'b000110, 6'b001100, 6'b011000, 6'b110000};
        apply(1'b1, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b1, fwd[i]);
            vectors++; if (out_a !== 3'(i) || dir_a !== ((i == 0) ? 2'd0 : 2'd1)) begin fails++; $display("FAIL sweep.fwd[%0d] got out=%0d dir=%0d want %0d %0d", i, out_a, dir_a, i, (i == 0) ? 0 : 1); end
        end
        vectors++; if (steps_a !== 8'd4) begin fails++; $display("FAIL sweep.fwd_steps got %0d want 4", steps_a); end
        vectors++; if (steps_b !== 2'd3) begin fails++; $display("FAIL sweep.sat_b got %0d want 3", steps_b); end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b1, rev[i]);
            vectors++; if (out_a !== 3'(3 - i) || dir_a !== 2'd2) begin fails++; $display("FAIL sweep.rev[%0d] got out=%0d dir=%0d want %0d 2", i, out_a, dir_a, 3 - i); end
        end
        vectors++; if (steps_a !== 8'd8 || steps_b !== 2'd3) begin fails++; $display("FAIL sweep.rev_steps got a=%0d b=%0d want 8 3", steps_a, steps_b); end
        apply(1'b0, 1'b0, 1'b1, 6'b110000);
        vectors++; if (dir_a !== 2'd0 || steps_a !== 8'd8) begin fails++; $display("FAIL sweep.hold got dir=%0d steps=%0d want 0 8", dir_a, steps_a); end
    endtask

    task automatic test_jump_error();
        apply(1'b1, 1'b0, 1'b0, 6'd0);
        apply(1'b0, 1'b0, 1'b1, 6'b110000);
        apply(1'b0, 1'b0, 1'b1, 6'b000110);
        vectors++; if (err_a !== 1'b0 || trk_a !== 1'b1) begin fails++; $display("FAIL jump.first got err=%0d trk=%0d want 0 1", err_a, trk_a); end
        vectors++; if (out_a !== 3'd0 || width_a !== 3'd2 || dir_a !== 2'd0) begin fails++; $display("FAIL jump.held got out=%0d width=%0d dir=%0d want 0 2 0", out_a, width_a, dir_a); end
        vectors++; if (err_b !== 1'b1 || trk_b !== 1'b0) begin fails++; $display("FAIL jump.limit1 got err=%0d trk=%0d want 1 0", err_b, trk_b); end
        apply(1'b0, 1'b0, 1'b1, 6'b000110);
        vectors++; if (err_a !== 1'b1 || trk_a !== 1'b0) begin fails++; $display("FAIL jump.second got err=%0d trk=%0d want 1 0", err_a, trk_a); end
        vectors++; if (out_a !== 3'd0 || width_a !== 3'd2 || dir_a !== 2'd0) begin fails++; $display("FAIL jump.err_hold got out=%0d width=%0d dir=%0d want 0 2 0", out_a, width_a, dir_a); end
    endtask

    task automatic test_bad_recover();
        apply(1'b1, 1'b0, 1'b0, 6'd0);
        apply(1'b0, 1'b0, 1'b1, 6'b110000);
        apply(1'b0, 1'b0, 1'b1, 6'b011000);
        apply(1'b0, 1'b0, 1'b1, 6'b110011);
        vectors++; if (err_a !== 1'b0 || out_a !== 3'd1 || dir_a !== 2'd1 || width_a !== 3'd2) begin fails++; $display("FAIL bad.held got err=%0d out=%0d dir=%0d width=%0d want 0 1 1 2", err_a, out_a, dir_a, width_a); end
        vectors++; if (err_b !== 1'b1) begin fails++; $display("FAIL bad.limit1 got err=%0d want 1", err_b); end
        apply(1'b0, 1'b0, 1'b1, 6'b011000);
        vectors++; if (err_a !== 1'b0 || trk_a !== 1'b1 || out_a !== 3'd1 || dir_a !== 2'd0) begin fails++; $display("FAIL bad.recover got err=%0d trk=%0d out=%0d dir=%0d want 0 1 1 0", err_a, trk_a, out_a, dir_a); end
        apply(1'b0, 1'b0, 1'b1, 6'b110011);
        vectors++; if (err_a !== 1'b0) begin fails++; $display("FAIL bad.cleared got err=%0d want 0", err_a); end
        apply(1'b0, 1'b0, 1'b1, 6'b110011);
        vectors++; if (err_a !== 1'b1 || trk_a !== 1'b0) begin fails++; $display("FAIL bad.escalate got err=%0d trk=%0d want 1 0", err_a, trk_a); end
        apply(1'b0, 1'b0, 1'b1, 6'b011000);
        vectors++; if (err_a !== 1'b1 || out_a !== 3'd1) begin fails++; $display("FAIL bad.sticky got err=%0d out=%0d want 1 1", err_a, out_a); end
    endtask

    task automatic test_clr_error();
        apply(1'b0, 1'b1, 1'b1, 6'b111000);
        vectors++; if (err_a !== 1'b0 || trk_a !== 1'b0 || steps_a !== 8'd0) begin fails++; $display("FAIL clr.state got err=%0d trk=%0d steps=%0d want 0 0 0", err_a, trk_a, steps_a); end
        vectors++; if (out_a !== 3'd1 || width_a !== 3'd2 || dir_a !== 2'd0) begin fails++; $display("FAIL clr.held got out=%0d width=%0d dir=%0d want 1 2 0", out_a, width_a, dir_a); end
        vectors++; if (err_b !== 1'b0 || steps_b !== 2'd0) begin fails++; $display("FAIL clr.b got err=%0d steps=%0d want 0 0", err_b, steps_b); end
        apply(1'b0, 1'b0, 1'b1, 6'b111000);
        vectors++; if (trk_a !== 1'b1 || out_a !== 3'd0 || width_a !== 3'd3) begin fails++; $display("FAIL clr.next got trk=%0d out=%0d width=%0d want 1 0 3", trk_a, out_a, width_a); end
    endtask

    task automatic test_absent_and_hold();
        apply(1'b1, 1'b0, 1'b0, 6'd0);
        apply(1'b0, 1'b0, 1'b1, 6'b110000);
        apply(1'b0, 1'b0, 1'b1, 6'b011000);
        apply(1'b0, 1'b0, 1'b1, 6'b000000);
        vectors++; if (trk_a !== 1'b0 || err_a !== 1'b0 || dir_a !== 2'd0) begin fails++; $display("FAIL absent.state got trk=%0d err=%0d dir=%0d want 0 0 0", trk_a, err_a, dir_a); end
        vectors++; if (out_a !== 3'd1 || width_a !== 3'd2 || steps_a !== 8'd1) begin fails++; $display("FAIL absent.held got out=%0d width=%0d steps=%0d want 1 2 1", out_a, width_a, steps_a); end
        apply(1'b0, 1'b0, 1'b0, 6'b110011);
        apply(1'b0, 1'b0, 1'b0, 6'b001110);
        vectors++; if (trk_a !== 1'b0 || err_a !== 1'b0 || out_a !== 3'd1 || width_a !== 3'd2) begin fails++; $display("FAIL en_low got trk=%0d err=%0d out=%0d width=%0d want 0 0 1 2", trk_a, err_a, out_a, width_a); end
        apply(1'b0, 1'b0, 1'b1, 6'b001100);
        vectors++; if (trk_a !== 1'b1 || out_a !== 3'd2 || dir_a !== 2'd0 || steps_a !== 8'd1) begin fails++; $display("FAIL absent.reenter got trk=%0d out=%0d dir=%0d steps=%0d want 1 2 0 1", trk_a, out_a, dir_a, steps_a); end
    endtask

    task automatic test_rst_mid();
        apply(1'b0, 1'b0, 1'b1, 6'b000110);
        apply(1'b1, 1'b1, 1'b1, 6'b000011);
        vectors++; if (out_a !== 3'd0 || width_a !== 3'd0 || dir_a !== 2'd0 || steps_a !== 8'd0) begin fails++; $display("FAIL rst_mid.a got out=%0d width=%0d dir=%0d steps=%0d want 0 0 0 0", out_a, width_a, dir_a, steps_a); end
        vectors++; if (trk_a !== 1'b0 || err_a !== 1'b0 || trk_b !== 1'b0 || out_b !== 3'd0) begin fails++; $display("FAIL rst_mid.flags got trk_a=%0d err_a=%0d trk_b=%0d out_b=%0d want 0 0 0 0", trk_a, err_a, trk_b, out_b); end
    endtask

    task automatic test_random();
        logic [5:0] v;
        int r, l, p;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                l = $urandom_range(2, 3);
                p = ma.out + $urandom_range(0, 2) - 1;
                if (p < 0) p = 0;
                if (p > 6 - l) p = 6 - l;
                v = 6'd0;
                for (int k = p; k < p + l; k++) v[5-k] = 1'b1;
            end else if (r < 8) begin
                v = 6'($urandom);
            end else begin
                v = 6'd0;
            end
            apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), v);
            vectors++; if (out_a !== 3'(ma.out) || width_a !== 3'(ma.width)) begin fails++; $display("FAIL rand[%0d].a_pos got out=%0d width=%0d want %0d %0d", n, out_a, width_a, ma.out, ma.width); end
            vectors++; if (dir_a !== 2'(ma.dir) || steps_a !== 8'(ma.steps)) begin fails++; $display("FAIL rand[%0d].a_dir got dir=%0d steps=%0d want %0d %0d", n, dir_a, steps_a, ma.dir, ma.steps); end
            vectors++; if (trk_a !== (ma.mode == 1) || err_a !== (ma.mode == 2)) begin fails++; $display("FAIL rand[%0d].a_state got trk=%0d err=%0d want mode %0d", n, trk_a, err_a, ma.mode); end
            vectors++; if (out_b !== 3'(mb.out) || width_b !== 3'(mb.width) || dir_b !== 2'(mb.dir)) begin fails++; $display("FAIL rand[%0d].b_pos got out=%0d width=%0d dir=%0d want %0d %0d %0d", n, out_b, width_b, dir_b, mb.out, mb.width, mb.dir); end
            vectors++; if (steps_b !== 2'(mb.steps) || trk_b !== (mb.mode == 1) || err_b !== (mb.mode == 2)) begin fails++; $display("FAIL rand[%0d].b_state got steps=%0d trk=%0d err=%0d want %0d mode %0d", n, steps_b, trk_b, err_b, mb.steps, mb.mode); end
        end
    endtask

    initial begin
        ma = '{0, 0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0, 0};
        test_reset();
        test_track_start();
        test_sweep();
        test_jump_error();
        test_bad_recover();
        test_clr_error();
        test_absent_and_hold();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
